// File: rtl/fp_div_seq.sv
// Sequential binary32 divider (restoring, one quotient bit/cycle), flush-to-zero; latency 1 (special) or 28 (normal).
// No backpressure: start is accepted only in IDLE and ignored while busy; done pulses for one cycle with the result.
module fp_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  logic [2:0]  r_mode,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_DIV, S_ROUND} state_t;

  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic [30:0] MAG_INF = 31'h7F800000;
  localparam logic [30:0] MAG_MAX = 31'h7F7FFFFF;

  state_t             r_state;
  logic [31:0]        r_x, r_y;
  logic [2:0]         r_rm;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [24:0]        r_rem;
  logic [23:0]        r_my;
  logic [25:0]        r_q;
  logic [4:0]         r_cnt;
  logic [31:0]        r_z;
  logic               r_ovrf, r_udrf, r_busy, r_done;

  // Operand classification for PREP
  logic [7:0]         w_ex, w_ey;
  logic               w_x_zero, w_y_zero, w_x_inf, w_y_inf, w_x_nan, w_y_nan;
  logic               w_sign;
  logic [23:0]        w_mx, w_my;
  logic               w_mx_lt;
  logic signed [9:0]  w_e_raw;
  logic               w_spec;
  logic [31:0]        w_spec_z;

  assign w_ex     = r_x[30:23];
  assign w_ey     = r_y[30:23];
  assign w_x_zero = (w_ex == 8'h00);
  assign w_y_zero = (w_ey == 8'h00);
  assign w_x_inf  = (w_ex == 8'hFF) && (r_x[22:0] == 23'd0);
  assign w_y_inf  = (w_ey == 8'hFF) && (r_y[22:0] == 23'd0);
  assign w_x_nan  = (w_ex == 8'hFF) && (r_x[22:0] != 23'd0);
  assign w_y_nan  = (w_ey == 8'hFF) && (r_y[22:0] != 23'd0);
  assign w_sign   = r_x[31] ^ r_y[31];
  assign w_mx     = {1'b1, r_x[22:0]};
  assign w_my     = {1'b1, r_y[22:0]};
  assign w_mx_lt  = (w_mx < w_my);
  assign w_e_raw  = {2'b00, w_ex} - {2'b00, w_ey} + 10'd127;

  always_comb begin
    w_spec   = 1'b1;
    w_spec_z = 32'h7FC00000;
    if (w_x_nan || w_y_nan || (w_x_zero && w_y_zero) || (w_x_inf && w_y_inf))
      w_spec_z = 32'h7FC00000;
    else if (w_x_inf)
      w_spec_z = {w_sign, MAG_INF};
    else if (w_y_inf)
      w_spec_z = {w_sign, 31'd0};
    else if (w_y_zero)
      w_spec_z = {w_sign, MAG_INF};
    else if (w_x_zero)
      w_spec_z = {w_sign, 31'd0};
    else
      w_spec = 1'b0;
  end

  // One restoring step; remainder stays below 2*my so 25 bits suffice
  logic        w_ge;
  logic [24:0] w_rem_sub;

  assign w_ge      = (r_rem >= {1'b0, r_my});
  assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_my}) : r_rem;

  // Rounding and range checks for ROUND
  logic               w_g, w_r, w_l, w_s, w_inc;
  logic [23:0]        w_mant_sum;
  logic signed [9:0]  w_exp_fin;
  logic               w_ovf, w_udf;
  logic [31:0]        w_ovf_z;

  assign w_l = r_q[2];
  assign w_g = r_q[1];
  assign w_r = r_q[0];
  assign w_s = |r_rem;

  always_comb begin
    w_inc = w_g & (w_l | w_r | w_s);
    case (r_rm)
      RM_RTZ:  w_inc = 1'b0;
      RM_RDN:  w_inc = r_sign & (w_g | w_r | w_s);
      RM_RUP:  w_inc = ~r_sign & (w_g | w_r | w_s);
      RM_RMM:  w_inc = w_g;
      default: w_inc = w_g & (w_l | w_r | w_s);
    endcase
  end

  assign w_mant_sum = {1'b0, r_q[24:2]} + {23'd0, w_inc};
  assign w_exp_fin  = r_exp + (w_mant_sum[23] ? 10'sd1 : 10'sd0);
  assign w_ovf      = (w_exp_fin >= 10'sd255);
  assign w_udf      = (w_exp_fin <= 10'sd0);

  always_comb begin
    w_ovf_z = {r_sign, MAG_INF};
    case (r_rm)
      RM_RTZ:  w_ovf_z = {r_sign, MAG_MAX};
      RM_RDN:  w_ovf_z = {r_sign, r_sign ? MAG_INF : MAG_MAX};
      RM_RUP:  w_ovf_z = {r_sign, r_sign ? MAG_MAX : MAG_INF};
      default: w_ovf_z = {r_sign, MAG_INF};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= 32'd0;
      r_y     <= 32'd0;
      r_rm    <= 3'd0;
      r_sign  <= 1'b0;
      r_exp   <= 10'sd0;
      r_rem   <= 25'd0;
      r_my    <= 24'd0;
      r_q     <= 26'd0;
      r_cnt   <= 5'd0;
      r_z     <= 32'd0;
      r_ovrf  <= 1'b0;
      r_udrf  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x     <= fp_X;
            r_y     <= fp_Y;
            r_rm    <= r_mode;
            r_busy  <= 1'b1;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          r_sign <= w_sign;
          if (w_spec) begin
            r_z     <= w_spec_z;
            r_ovrf  <= 1'b0;
            r_udrf  <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            // Pre-normalise so the quotient lands in [1,2)
            r_exp   <= w_mx_lt ? (w_e_raw - 10'sd1) : w_e_raw;
            r_rem   <= w_mx_lt ? {w_mx, 1'b0} : {1'b0, w_mx};
            r_my    <= w_my;
            r_q     <= 26'd0;
            r_cnt   <= 5'd0;
            r_state <= S_DIV;
          end
        end
        S_DIV: begin
          r_q   <= {r_q[24:0], w_ge};
          r_rem <= w_rem_sub << 1;
          if (r_cnt == 5'd25) begin
            r_cnt   <= 5'd0;
            r_state <= S_ROUND;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_ROUND: begin
          if (w_ovf) begin
            r_z    <= w_ovf_z;
            r_ovrf <= 1'b1;
            r_udrf <= 1'b0;
          end else if (w_udf) begin
            r_z    <= {r_sign, 31'd0};
            r_ovrf <= 1'b0;
            r_udrf <= 1'b1;
          end else begin
            r_z    <= {r_sign, w_exp_fin[7:0], w_mant_sum[22:0]};
            r_ovrf <= 1'b0;
            r_udrf <= 1'b0;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign fp_Z = r_z;
  assign ovrf = r_ovrf;
  assign udrf = r_udrf;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq: table of vectors with hand-computed results plus
// handshake and mid-operation reset sequences.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] fp_X, fp_Y;
  logic [2:0]  r_mode;
  logic [31:0] fp_Z;
  logic        ovrf, udrf, busy, done;

  int checks = 0;
  int errors = 0;

  fp_div_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .fp_X   (fp_X),
    .fp_Y   (fp_Y),
    .r_mode (r_mode),
    .fp_Z   (fp_Z),
    .ovrf   (ovrf),
    .udrf   (udrf),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  m;
    logic [31:0] z;
    logic        ov;
    logic        ud;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts edges after the start-sampling edge until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (1) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done === 1'b1) break;
      if (n >= 60) break;
    end
  endtask

  // Called at a negedge; returns at the negedge after the start-sampling edge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
    fp_X   = x;
    fp_Y   = y;
    r_mode = m;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    issue(v.x, v.y, v.m);
    chk({v.name, " busy"}, 32'(busy), 32'd1);
    wait_done(n);
    chk({v.name, " latency"}, 32'(n), 32'(v.lat));
    chk({v.name, " fp_Z"}, fp_Z, v.z);
    chk({v.name, " ovrf"}, 32'(ovrf), 32'(v.ov));
    chk({v.name, " udrf"}, 32'(udrf), 32'(v.ud));
    chk({v.name, " busy_in_done"}, 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({v.name, " done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int seen;

    vecs[0]  = '{"6/2 rne",       32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 1'b0, 1'b0, 28};
    vecs[1]  = '{"1/3 rne",       32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, 1'b0, 1'b0, 28};
    vecs[2]  = '{"1/3 rtz",       32'h3F800000, 32'h40400000, 3'b001, 32'h3EAAAAAA, 1'b0, 1'b0, 28};
    vecs[3]  = '{"1/3 rup",       32'h3F800000, 32'h40400000, 3'b011, 32'h3EAAAAAB, 1'b0, 1'b0, 28};
    vecs[4]  = '{"1/3 rdn",       32'h3F800000, 32'h40400000, 3'b010, 32'h3EAAAAAA, 1'b0, 1'b0, 28};
    vecs[5]  = '{"-1/3 rdn",      32'hBF800000, 32'h40400000, 3'b010, 32'hBEAAAAAB, 1'b0, 1'b0, 28};
    vecs[6]  = '{"1/3 rmm",       32'h3F800000, 32'h40400000, 3'b100, 32'h3EAAAAAB, 1'b0, 1'b0, 28};
    vecs[7]  = '{"1/3 mode5",     32'h3F800000, 32'h40400000, 3'b101, 32'h3EAAAAAB, 1'b0, 1'b0, 28};
    vecs[8]  = '{"1/0",           32'h3F800000, 32'h00000000, 3'b000, 32'h7F800000, 1'b0, 1'b0, 1};
    vecs[9]  = '{"0/0",           32'h00000000, 32'h00000000, 3'b000, 32'h7FC00000, 1'b0, 1'b0, 1};
    vecs[10] = '{"sub/1",         32'h00400000, 32'h3F800000, 3'b000, 32'h00000000, 1'b0, 1'b0, 1};
    vecs[11] = '{"1/-inf",        32'h3F800000, 32'hFF800000, 3'b000, 32'h80000000, 1'b0, 1'b0, 1};
    vecs[12] = '{"nan/1",         32'h7FC00001, 32'h3F800000, 3'b000, 32'h7FC00000, 1'b0, 1'b0, 1};
    vecs[13] = '{"inf/-inf",      32'h7F800000, 32'hFF800000, 3'b001, 32'h7FC00000, 1'b0, 1'b0, 1};
    vecs[14] = '{"ovf rne",       32'h7F000000, 32'h3E800000, 3'b000, 32'h7F800000, 1'b1, 1'b0, 28};
    vecs[15] = '{"ovf rtz",       32'h7F000000, 32'h3E800000, 3'b001, 32'h7F7FFFFF, 1'b1, 1'b0, 28};
    vecs[16] = '{"ovf rdn pos",   32'h7F000000, 32'h3E800000, 3'b010, 32'h7F7FFFFF, 1'b1, 1'b0, 28};
    vecs[17] = '{"udf",           32'h00800000, 32'h40000000, 3'b000, 32'h00000000, 1'b0, 1'b1, 28};

    rst    = 1'b1;
    start  = 1'b0;
    fp_X   = 32'd0;
    fp_Y   = 32'd0;
    r_mode = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset fp_Z", fp_Z, 32'd0);
    chk("reset ovrf", 32'(ovrf), 32'd0);
    chk("reset udrf", 32'(udrf), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);

    for (int i = 0; i < 18; i++) run_vec(vecs[i]);

    // start pulses while busy must be ignored; start in the done cycle is taken
    issue(32'h40C00000, 32'h40000000, 3'b000);
    repeat (3) begin
      fp_X   = 32'h7F000000;
      fp_Y   = 32'h3E800000;
      r_mode = 3'b001;
      start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start  = 1'b0;
    end
    wait_done(n);
    chk("hs first latency", 32'(n + 3), 32'd28);
    chk("hs first fp_Z", fp_Z, 32'h40400000);
    chk("hs first ovrf", 32'(ovrf), 32'd0);
    issue(32'h3F800000, 32'h40400000, 3'b000);
    chk("hs done one cycle", 32'(done), 32'd0);
    chk("hs second busy", 32'(busy), 32'd1);
    wait_done(n);
    chk("hs second latency", 32'(n), 32'd28);
    chk("hs second fp_Z", fp_Z, 32'h3EAAAAAB);

    // Reset during DIV
    @(negedge clk);
    issue(32'h40C00000, 32'h40000000, 3'b000);
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst fp_Z", fp_Z, 32'd0);
    chk("midrst ovrf", 32'(ovrf), 32'd0);
    chk("midrst udrf", 32'(udrf), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk("midrst no done", 32'(seen), 32'd0);
    run_vec(vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
